uart_rx_deframer: RTL and testbench

Asynchronous-serial receive front end of the UART path. Takes the raw `rs232_rx` pin, synchronises it, detects and validates the start bit, mid-bit samples 8 data bits LSB first plus the stop bit, and presents each received byte as a one-cycle valid strobe. It feeds the byte-handling and transmit-side logic inside `uart_top`, and flags framing and, optionally, parity errors.

---
 rtl/uart_rx_deframer.sv | 152 +++++++++++++++
 tb/tb_uart_rx_deframer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rs232_rx, mid-bit samples an 8-bit LSB-first frame, strobes byte/error flags.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t        state;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
`ifdef UART_RX_PARITY_EN
  logic          par_mismatch;
  logic          parity_err_q;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values of rx_s2, cnt and idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mismatch <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_s1     <= rs232_rx;
      rx_s2     <= rx_s1;
      rx_d      <= rx_s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_d && !rx_s2) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            // A line already high again at mid-start is a glitch, not a frame.
            if (!rx_s2) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rx_s2;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt          <= '0;
            par_mismatch <= (^shift) ^ rx_s2;
            state        <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            // Leaving at mid-stop lets the next start edge be caught without loss.
            if (rx_s2) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_mismatch;
`endif
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must return high before another start is armed.
          if (rx_s2) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLKS_PER_BIT = 16: table-driven frames plus glitch, break, back-to-back and reset sequences.
module tb_uart_rx_deframer;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Strobe cycle relative to the negedge that drives the start bit low: 2 sync + HALF + stop-sample + 1.
  localparam int OFS = 2 + HALF + (NBITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, rx_busy;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rs232_rx(rs232_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .parity_err(parity_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_err = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_both = 0;
  int last_valid_cyc = 0, last_ferr_cyc = 0, last_perr_cyc = 0, busy_fall_cyc = 0;
  logic prev_busy = 1'b0;
  logic [7:0] vq_data[$];
  int vq_cyc[$];
  logic par_flip = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      vq_data.push_back(rx_data);
      vq_cyc.push_back(cyc);
    end
    if (frame_err) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (parity_err) begin
      n_perr++;
      last_perr_cyc = cyc;
    end
    if (rx_valid && frame_err) n_both++;
    if (prev_busy && !rx_busy) busy_fall_cyc = cyc;
    prev_busy = rx_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rs232_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int c);
    c = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, CPB);
`endif
    hold(stop, CPB);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'h0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c, c2, r, v0, f0, p0, q0;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
    vecs[1] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
    vecs[2] = '{8'hA3, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[3] = '{8'h42, 1'b1, 1'b1, 1'b0, 8'h42};

    rst = 1'b1;
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 8);
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      send_frame(vecs[i].data, vecs[i].stop, c);
      check("valid_count", 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      check("ferr_count", 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      check("perr_count", 32'(n_perr - p0), 32'h0);
      check("rx_data", 32'(rx_data), 32'(vecs[i].exp_data));
      if (vecs[i].exp_valid) begin
        check("valid_cycle", 32'(last_valid_cyc - c), 32'(OFS));
        check("busy_fall_cycle", 32'(busy_fall_cyc - c), 32'(OFS));
      end else begin
        check("ferr_cycle", 32'(last_ferr_cyc - c), 32'(OFS));
      end
      if (!vecs[i].stop) begin
        v0 = n_valid; f0 = n_ferr;
        hold(1'b0, 40);
        check("break_no_strobe", 32'((n_valid - v0) + (n_ferr - f0)), 32'h0);
        check("break_busy", 32'(rx_busy), 32'h1);
        r = cyc;
        hold(1'b1, 8);
        check("wait_high_exit", 32'(busy_fall_cyc - r), 32'h3);
      end
    end

    // Four-cycle low glitch must be rejected at mid-start.
    hold(1'b1, 8);
    v0 = n_valid; f0 = n_ferr;
    c = cyc;
    hold(1'b0, 4);
    hold(1'b1, 4);
    check("glitch_busy_high", 32'(rx_busy), 32'h1);
    hold(1'b1, 8);
    check("glitch_busy_fall", 32'(busy_fall_cyc - c), 32'(2 + HALF + 1));
    check("glitch_no_strobe", 32'((n_valid - v0) + (n_ferr - f0)), 32'h0);
    hold(1'b1, 8);
    v0 = n_valid;
    send_frame(8'h3C, 1'b1, c);
    check("after_glitch_valid", 32'(n_valid - v0), 32'h1);
    check("after_glitch_data", 32'(rx_data), 32'h3C);

    // Back-to-back frames with no idle gap.
    hold(1'b1, 8);
    q0 = vq_data.size();
    send_frame(8'h00, 1'b1, c);
    send_frame(8'hFF, 1'b1, c2);
    hold(1'b1, 8);
    check("b2b_count", 32'(vq_data.size() - q0), 32'h2);
    if (vq_data.size() >= q0 + 2) begin
      check("b2b_data0", 32'(vq_data[q0]), 32'h00);
      check("b2b_data1", 32'(vq_data[q0 + 1]), 32'hFF);
      check("b2b_spacing", 32'(vq_cyc[q0 + 1] - vq_cyc[q0]), 32'(NBITS * CPB));
      check("b2b_first_cycle", 32'(vq_cyc[q0] - c), 32'(OFS));
    end

    // Reset in the middle of data bit 3 of 0xF8; remaining bits keep the line high.
    hold(1'b1, 8);
    v0 = n_valid; f0 = n_ferr;
    hold(1'b0, CPB);
    hold(1'b0, 3 * CPB);
    hold(1'b1, HALF);
    check("pre_reset_busy", 32'(rx_busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midframe_reset");
    rst = 1'b0;
    hold(1'b1, 200);
    check("aborted_no_strobe", 32'((n_valid - v0) + (n_ferr - f0)), 32'h0);
    check("aborted_idle", 32'(rx_busy), 32'h0);
    v0 = n_valid;
    send_frame(8'h96, 1'b1, c);
    check("post_reset_valid", 32'(n_valid - v0), 32'h1);
    check("post_reset_data", 32'(rx_data), 32'h96);
    check("post_reset_cycle", 32'(last_valid_cyc - c), 32'(OFS));

`ifdef UART_RX_PARITY_EN
    hold(1'b1, 8);
    v0 = n_valid; p0 = n_perr;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, c);
    check("par_ok_valid", 32'(n_valid - v0), 32'h1);
    check("par_ok_perr", 32'(n_perr - p0), 32'h0);
    hold(1'b1, 8);
    v0 = n_valid; p0 = n_perr;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, c);
    par_flip = 1'b0;
    check("par_bad_valid", 32'(n_valid - v0), 32'h1);
    check("par_bad_perr", 32'(n_perr - p0), 32'h1);
    check("par_bad_same_cycle", 32'(last_perr_cyc), 32'(last_valid_cyc));
    check("par_bad_cycle", 32'(last_valid_cyc - c), 32'(OFS));
`endif

    hold(1'b1, 8);
    check("valid_ferr_overlap", 32'(n_both), 32'h0);
`ifndef UART_RX_PARITY_EN
    check("parity_err_never", 32'(n_perr), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
